f1_lights_seq: RTL
==================

Name: f1_lights_seq

Overview:
- Parametrised start-light sequencer for the F1 reaction-timer datapath.
- On a trigger, it lights WIDTH lamps one per tick from LSB upward, and holds all lamps lit for a programmable delay counted in clk cycles.
- It then extinguishes all lamps and emits a one-cycle lights_out pulse, which the reaction timer uses as its start event.
- Adds trigger, abort, variable hold and status outputs beyond the fixed free-running fill counter.

Parameters:
- WIDTH, 8, number of lamps (width of data_out); legal range 2..32.
- DELAY_W, 7, width of the hold-delay input and hold counter.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset; synchronous, active-high.
- tick, in, 1, lamp-step strobe (one-cycle pulses from the clock divider); used only in FILL.
- trigger, in, 1, start request; sampled only in IDLE.
- abort, in, 1, cancel the sequence; return to IDLE with lamps off and no lights_out pulse.
- delay_in, in, DELAY_W, hold length (from LFSR); latched on the accepted trigger.
- data_out, out, WIDTH, lamp vector; bit i lit means lamp i is on.
- busy, out, 1, high in FILL or HOLD.
- lights_out, out, 1, one-cycle pulse when the lamps go dark at the end of HOLD.

Behaviour:
- All outputs are registered. Reset values: state=IDLE, data_out=0, busy=0, lights_out=0, hold_cnt=0, delay_lat=0.
- rst has priority over everything, in any state including mid-FILL and mid-HOLD.
- abort has priority over trigger, tick and hold expiry. In FILL or HOLD, abort forces IDLE and data_out=0 on the next edge, with lights_out=0. In IDLE, abort has no effect.
- IDLE:
  - data_out=0, busy=0.
  - trigger=1 and abort=0: next edge moves to FILL, sets busy=1 and delay_lat<=delay_in. data_out remains 0.
  - A tick in the same cycle as the trigger is ignored.
- FILL:
  - On each cycle with tick=1: data_out <= {data_out[WIDTH-2:0],1'b1}.
  - On the tick that makes data_out all-ones (the WIDTH-th tick in FILL): same edge moves to HOLD and loads hold_cnt<=delay_lat.
  - Cycles without tick: no change.
  - trigger is ignored.
- HOLD:
  - data_out stays all-ones; tick and trigger are ignored.
  - Each clk cycle: if hold_cnt==0, the next edge sets data_out=0, lights_out=1, busy=0 and state=IDLE. Otherwise hold_cnt decrements.
  - The all-ones vector is therefore visible for exactly delay_lat+1 cycles. delay_lat=0 gives 1 cycle.
- lights_out:
  - Asserted for exactly one cycle: the first cycle of IDLE after a HOLD expiry. It coincides with the first cycle of data_out=0.
  - Cleared automatically on the following cycle.
- Re-trigger:
  - trigger held high during the lights_out cycle starts a new sequence on the next edge.
  - A trigger held continuously restarts immediately after each completed sequence.
- delay_in changes after the trigger has no effect on the current sequence.
- data_out values are always of the form 2^k-1 with 0<=k<=WIDTH. No other value is ever produced.
- No illegal-state lockup: any undefined state encoding recovers to IDLE on the next edge with data_out=0.

Test Plan:
- Reset: assert rst for 2 cycles mid-FILL with data_out=0x07 -> data_out=0x00, busy=0, lights_out=0, state IDLE.
- Nominal run (WIDTH=8, delay_in=5): trigger, then 8 ticks spaced 3 cycles apart -> data_out steps 0x01,0x03,...,0xFF. 0xFF is held for 6 cycles, then 0x00 with lights_out high for exactly 1 cycle, busy falls on the same edge.
- Zero delay (delay_in=0) -> 0xFF is visible for exactly 1 cycle, then lights_out pulses.
- Abort in HOLD (delay_in=100, abort at hold cycle 10) -> data_out=0x00 on the next edge, lights_out never asserts, busy=0.
- Ignored inputs: trigger pulses during FILL/HOLD, ticks during HOLD and IDLE, and delay_in changed to 0 after the trigger -> sequence timing is identical to the nominal run.
- Back-to-back: trigger held high with delay_in=3 -> a second FILL starts the cycle after the lights_out pulse. Then WIDTH=4 instance: data_out sequence 0x1,0x3,0x7,0xF, then 0x0.

Source files
------------

// File: rtl/f1_lights_seq.sv
// Start-light sequencer: fills WIDTH lamps one per tick, holds all lit for delay_lat+1 cycles, then
// extinguishes them with a one-cycle lights_out pulse. All outputs registered; no backpressure.
module f1_lights_seq #(
  parameter int WIDTH   = 8,
  parameter int DELAY_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               trigger,
  input  logic               abort,
  input  logic [DELAY_W-1:0] delay_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy,
  output logic               lights_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  logic [DELAY_W-1:0] hold_cnt;
  logic [DELAY_W-1:0] delay_lat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      data_out   <= '0;
      busy       <= 1'b0;
      lights_out <= 1'b0;
      hold_cnt   <= '0;
      delay_lat  <= '0;
    end else begin
      lights_out <= 1'b0;
      case (state)
        IDLE: begin
          data_out <= '0;
          busy     <= 1'b0;
          if (trigger && !abort) begin
            state     <= FILL;
            busy      <= 1'b1;
            delay_lat <= delay_in;
          end
        end
        FILL: begin
          if (abort) begin
            state    <= IDLE;
            data_out <= '0;
            busy     <= 1'b0;
          end else if (tick) begin
            data_out <= {data_out[WIDTH-2:0], 1'b1};
            // Lamps fill from the LSB, so the top-but-one bit marks the final step.
            if (data_out[WIDTH-2]) begin
              state    <= HOLD;
              hold_cnt <= delay_lat;
            end
          end
        end
        HOLD: begin
          if (abort) begin
            state    <= IDLE;
            data_out <= '0;
            busy     <= 1'b0;
          end else if (hold_cnt == '0) begin
            state      <= IDLE;
            data_out   <= '0;
            busy       <= 1'b0;
            lights_out <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          data_out <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
